// File: rtl/dbus_xbar.sv
// Data-bus router from the core data port to NS slaves, decoded on the top SW address bits.
// It adds per-slave ready/wait handshakes, a wait-state timeout, unmapped-region errors and a registered read return.
module dbus_xbar #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int SW     = 3,
  parameter int NS     = 2,
  parameter int TO_CYC = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [AW-1:0]    m_addr,
  input  logic [DW-1:0]    m_din,
  output logic             m_ready,
  output logic             m_rvalid,
  output logic [DW-1:0]    m_dout,
  output logic             m_err,
  output logic [NS-1:0]    s_req,
  output logic             s_we,
  output logic [AW-SW-1:0] s_addr,
  output logic [DW-1:0]    s_din,
  input  logic [NS-1:0]    s_ready,
  input  logic [NS*DW-1:0] s_dout
);

  localparam int              CW       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam bit              TO_EN    = (TO_CYC != 0);
  localparam logic [CW-1:0]   CNT_LAST = (TO_CYC > 0) ? CW'(TO_CYC - 1) : '0;
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [SW:0]     NS_LIM   = (SW + 1)'(NS);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [SW-1:0] sel_q, sel_d;

  logic [SW-1:0] idx;
  logic          mapped;
  logic          slave_ready;
  logic          timeout_now;
  logic          accept;
  logic [DW-1:0] rdata;

  assign idx    = m_addr[AW-1:AW-SW];
  assign mapped = ({1'b0, idx} < NS_LIM);

  assign s_we   = m_we;
  assign s_addr = m_addr[AW-SW-1:0];
  assign s_din  = m_din;

  // An unmapped index never matches a slave, so slave_ready stays 0 for it.
  always_comb begin
    slave_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (idx == SW'(i)) slave_ready = s_ready[i];
    end
  end

  assign timeout_now = TO_EN && (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
  assign m_ready     = m_req & (~mapped | slave_ready | timeout_now);
  assign accept      = m_req & m_ready;

  always_comb begin
    s_req = '0;
    if (rst_n && m_req && mapped && !timeout_now) begin
      for (int i = 0; i < NS; i++) begin
        s_req[i] = (idx == SW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (m_req && mapped && !slave_ready) state_d = ST_WAIT;
      ST_WAIT: if (!m_req || accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The first stalled cycle is spent in IDLE; the counter then runs 0.. through WAIT.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT && m_req && !accept) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_d  = accept & ~m_we;
    err_d = accept & (~mapped | timeout_now);
    sel_d = accept ? idx : sel_q;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q == SW'(i)) rdata = s_dout[i*DW +: DW];
    end
  end

  assign m_rvalid = rd_q;
  assign m_err    = err_q;
  assign m_dout   = (rd_q && !err_q) ? rdata : '0;

endmodule

// File: tb/tb_dbus_xbar.sv
// Directed bench for dbus_xbar: a per-cycle vector table plus hand sequences for
// wait states, timeout and asynchronous reset.
module tb_dbus_xbar;

  logic        clk;
  logic        rst_n;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_din;
  logic        m_ready;
  logic        m_rvalid;
  logic [15:0] m_dout;
  logic        m_err;
  logic [1:0]  s_req;
  logic        s_we;
  logic [12:0] s_addr;
  logic [15:0] s_din;
  logic [1:0]  s_ready;
  logic [31:0] s_dout;

  int checks = 0;
  int errors = 0;

  dbus_xbar #(.DW(16), .AW(16), .SW(3), .NS(2), .TO_CYC(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_dout   (m_dout),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_ready  (s_ready),
    .s_dout   (s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  rdy;
    logic [31:0] sdout;
    logic        exp_ready;
    logic [1:0]  exp_sreq;
    logic        exp_rvalid;
    logic        exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, leaving time to sample before the rising edge.
  task automatic apply_stimulus(input logic req, input logic we, input logic [15:0] addr,
                                input logic [15:0] din, input logic [1:0] rdy, input logic [31:0] sdout);
    @(negedge clk);
    m_req   = req;
    m_we    = we;
    m_addr  = addr;
    m_din   = din;
    s_ready = rdy;
    s_dout  = sdout;
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " s_req"},    32'(s_req),    32'h0);
    check_output({tag, " m_rvalid"}, 32'(m_rvalid), 32'h0);
    check_output({tag, " m_err"},    32'(m_err),    32'h0);
    check_output({tag, " m_dout"},   32'(m_dout),   32'h0);
  endtask

  // Holds a read against a never-ready slave; the release must come after 15 low-ready cycles.
  task automatic measure_timeout(input logic [15:0] addr, input string tag);
    int low = 0;
    apply_stimulus(1'b1, 1'b0, addr, 16'h0, 2'b00, 32'h0);
    while (!m_ready && low < 40) begin
      low++;
      apply_stimulus(1'b1, 1'b0, addr, 16'h0, 2'b00, 32'h0);
    end
    check_output({tag, " stalled cycles"}, 32'(low), 32'd15);
    check_output({tag, " s_req at timeout"}, 32'(s_req), 32'h0);
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 32'hC0DE_F00D);
    check_output({tag, " m_rvalid"}, 32'(m_rvalid), 32'h1);
    check_output({tag, " m_err"},    32'(m_err),    32'h1);
    check_output({tag, " m_dout"},   32'(m_dout),   32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 16'h0005, 16'hABCD, 2'b01, 32'h0000_0000, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h2003, 16'h0000, 2'b10, 32'h0000_0000, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 32'h1234_5555, 1'b0, 2'b00, 1'b1, 1'b0, 16'h1234};
    vecs[3]  = '{1'b1, 1'b0, 16'hE000, 16'h0000, 2'b11, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 16'h4000, 16'h5A5A, 2'b11, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b01, 32'hAAAA_BBBB, 1'b1, 2'b01, 1'b0, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h2020, 16'h0000, 2'b10, 32'h1111_2222, 1'b1, 2'b10, 1'b1, 1'b0, 16'h2222};
    vecs[8]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 2'b01, 32'h3333_4444, 1'b1, 2'b01, 1'b1, 1'b0, 16'h3333};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 32'h5555_6666, 1'b0, 2'b00, 1'b1, 1'b0, 16'h6666};
    vecs[10] = '{1'b1, 1'b0, 16'h1FFF, 16'h0000, 2'b01, 32'h0000_0000, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 32'h0000_7777, 1'b0, 2'b00, 1'b1, 1'b0, 16'h7777};

    rst_n   = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = 16'h0;
    m_din   = 16'h0;
    s_ready = 2'b00;
    s_dout  = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    check_output("reset m_ready", 32'(m_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors: combinational outputs for this row, registered outputs from the row before.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].rdy, vecs[i].sdout);
      check_output($sformatf("vec%0d m_ready", i),  32'(m_ready),  32'(vecs[i].exp_ready));
      check_output($sformatf("vec%0d s_req", i),    32'(s_req),    32'(vecs[i].exp_sreq));
      check_output($sformatf("vec%0d m_rvalid", i), 32'(m_rvalid), 32'(vecs[i].exp_rvalid));
      check_output($sformatf("vec%0d m_err", i),    32'(m_err),    32'(vecs[i].exp_err));
      check_output($sformatf("vec%0d m_dout", i),   32'(m_dout),   32'(vecs[i].exp_dout));
      if (vecs[i].req) begin
        check_output($sformatf("vec%0d s_addr", i), 32'(s_addr), 32'(vecs[i].addr[12:0]));
        check_output($sformatf("vec%0d s_din", i),  32'(s_din),  32'(vecs[i].din));
        check_output($sformatf("vec%0d s_we", i),   32'(s_we),   32'(vecs[i].we));
      end
    end

    // Three wait states on slave 0, accepted on the fourth cycle.
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, 32'h0);
      check_output($sformatf("wait%0d m_ready", c), 32'(m_ready), 32'h0);
      check_output($sformatf("wait%0d s_req", c),   32'(s_req),   32'h1);
      check_output($sformatf("wait%0d m_rvalid", c), 32'(m_rvalid), 32'h0);
    end
    apply_stimulus(1'b1, 1'b0, 16'h0100, 16'h0, 2'b01, 32'h0);
    check_output("wait accept m_ready", 32'(m_ready), 32'h1);
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 32'h0000_9999);
    check_output("wait m_rvalid", 32'(m_rvalid), 32'h1);
    check_output("wait m_err",    32'(m_err),    32'h0);
    check_output("wait m_dout",   32'(m_dout),   32'h9999);

    measure_timeout(16'h0200, "timeout");

    // Reset asserted mid-cycle while an error response is being presented.
    apply_stimulus(1'b1, 1'b0, 16'hC000, 16'h0, 2'b00, 32'h0);
    apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0, 2'b01, 32'h1357_2468);
    check_output("pre-reset m_err", 32'(m_err), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset resp");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back reads, then a reset while stalled in WAIT.
    apply_stimulus(1'b1, 1'b0, 16'h2000, 16'h0, 2'b10, 32'h0);
    check_output("b2b s_req", 32'(s_req), 32'h2);
    apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 32'hABAB_0101);
    check_output("b2b m_rvalid", 32'(m_rvalid), 32'h1);
    check_output("b2b m_dout",   32'(m_dout),   32'hABAB);
    check_output("b2b stall m_ready", 32'(m_ready), 32'h0);
    apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 32'h0);
    apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset wait");
    @(negedge clk);
    rst_n = 1'b1;
    m_req = 1'b0;

    // A full timeout length after reset shows the stalled access and its count were dropped.
    measure_timeout(16'h0040, "post-reset timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
